// File: rtl/ide_pio_sequencer.sv
// IDE PIO strobe sequencer: turns a decoded 68020 cycle in the IDE window into
// timed IDECS/IOR/IOW with IORDY stretching, a wait timeout and a 16-bit DSACK.
module ide_pio_sequencer #(
    parameter int T_SETUP   = 1,
    parameter int T_ACTIVE  = 4,
    parameter int T_RECOVER = 2,
    parameter int T_TIMEOUT = 255
) (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       AS20,
    input  logic       DS20,
    input  logic       RW20,
    input  logic       IDE_SEL,
    input  logic       A12,
    input  logic       IORDY,
    output logic       IOR,
    output logic       IOW,
    output logic [1:0] IDECS,
    output logic [1:0] DSACK_N,
    output logic       TIMEOUT
);

    // state     | meaning
    // S_IDLE    | bus idle, waiting for a qualified request
    // S_SETUP   | IDECS asserted, strobe not yet asserted
    // S_ACTIVE  | strobe asserted, minimum time then IORDY wait
    // S_ACK     | DSACK asserted, holding until the CPU negates AS20
    // S_RECOVER | everything idle for the recovery time
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ACTIVE  = 3'd2,
        S_ACK     = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    localparam int TS = (T_SETUP   < 1) ? 1 : T_SETUP;
    localparam int TA = (T_ACTIVE  < 1) ? 1 : T_ACTIVE;
    localparam int TR = (T_RECOVER < 1) ? 1 : T_RECOVER;
    localparam logic [7:0] SETUP_LOAD   = 8'(TS - 1);
    localparam logic [7:0] ACTIVE_LOAD  = 8'(TA - 1);
    localparam logic [7:0] RECOVER_LOAD = 8'(TR - 1);
    localparam logic [7:0] WAIT_LIMIT   = 8'(T_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] wait_q, wait_d;
    logic       rw_q, rw_d;
    logic       a12_q, a12_d;
    logic       ior_d, iow_d, timeout_d;
    logic [1:0] idecs_d, dsack_d;
    logic       to_recover;
    logic       to_ack;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        rw_d       = rw_q;
        a12_d      = a12_q;
        ior_d      = IOR;
        iow_d      = IOW;
        idecs_d    = IDECS;
        dsack_d    = DSACK_N;
        timeout_d  = 1'b0;
        to_recover = 1'b0;
        to_ack     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // writes wait for DS20 so data is stable before IOW falls
                if (!AS20 && !IDE_SEL && (RW20 || !DS20)) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LOAD;
                    rw_d    = RW20;
                    a12_d   = A12;
                    idecs_d = A12 ? 2'b01 : 2'b10;
                end
            end
            S_SETUP: begin
                if (AS20) begin
                    to_recover = 1'b1;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_ACTIVE;
                    cnt_d   = ACTIVE_LOAD;
                    wait_d  = 8'd0;
                    ior_d   = ~rw_q;
                    iow_d   = rw_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ACTIVE: begin
                if (AS20) begin
                    to_recover = 1'b1;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (IORDY) begin
                    to_ack = 1'b1;
                end else if (wait_q == WAIT_LIMIT) begin
                    to_ack    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_ACK: begin
                if (AS20) begin
                    to_recover = 1'b1;
                end
            end
            S_RECOVER: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (to_ack) begin
            state_d = S_ACK;
            dsack_d = 2'b01;
        end

        if (to_recover) begin
            state_d = S_RECOVER;
            cnt_d   = RECOVER_LOAD;
            ior_d   = 1'b1;
            iow_d   = 1'b1;
            idecs_d = 2'b11;
            dsack_d = 2'b11;
        end
    end

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            wait_q  <= 8'd0;
            rw_q    <= 1'b1;
            a12_q   <= 1'b0;
            IOR     <= 1'b1;
            IOW     <= 1'b1;
            IDECS   <= 2'b11;
            DSACK_N <= 2'b11;
            TIMEOUT <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            rw_q    <= rw_d;
            a12_q   <= a12_d;
            IOR     <= ior_d;
            IOW     <= iow_d;
            IDECS   <= idecs_d;
            DSACK_N <= dsack_d;
            TIMEOUT <= timeout_d;
        end
    end

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Bench for ide_pio_sequencer: two instances (default timing and a short-timeout
// variant) share one bus; expected outputs come from per-transaction edge arithmetic.
module tb_ide_pio_sequencer;

    logic       CLKCPU = 1'b0;
    logic       RESET  = 1'b1;
    logic       AS20   = 1'b1;
    logic       DS20   = 1'b1;
    logic       RW20   = 1'b1;
    logic       IDE_SEL = 1'b1;
    logic       A12    = 1'b0;
    logic       IORDY  = 1'b1;

    logic       ior   [2];
    logic       iow   [2];
    logic [1:0] idecs [2];
    logic [1:0] dsack [2];
    logic       tmo   [2];

    // effective timing of each instance (instance 1 has T_ACTIVE=0, treated as 1)
    int ts [2] = '{1, 3};
    int ta [2] = '{4, 1};
    int tr [2] = '{2, 3};
    int tt [2] = '{255, 8};

    int cyc = 0;
    int idle_from [2];
    int n_checks = 0;
    int n_fail = 0;

    ide_pio_sequencer dut0 (
        .CLKCPU(CLKCPU), .RESET(RESET), .AS20(AS20), .DS20(DS20), .RW20(RW20),
        .IDE_SEL(IDE_SEL), .A12(A12), .IORDY(IORDY),
        .IOR(ior[0]), .IOW(iow[0]), .IDECS(idecs[0]), .DSACK_N(dsack[0]), .TIMEOUT(tmo[0])
    );

    ide_pio_sequencer #(.T_SETUP(3), .T_ACTIVE(0), .T_RECOVER(3), .T_TIMEOUT(8)) dut1 (
        .CLKCPU(CLKCPU), .RESET(RESET), .AS20(AS20), .DS20(DS20), .RW20(RW20),
        .IDE_SEL(IDE_SEL), .A12(A12), .IORDY(IORDY),
        .IOR(ior[1]), .IOW(iow[1]), .IDECS(idecs[1]), .DSACK_N(dsack[1]), .TIMEOUT(tmo[1])
    );

    always #5 CLKCPU = ~CLKCPU;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLKCPU);
        cyc++;
        #1;
    endtask

    task automatic chk_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_ior%0d", tag, i),   8'(ior[i]),   8'h1);
            chk($sformatf("%s_iow%0d", tag, i),   8'(iow[i]),   8'h1);
            chk($sformatf("%s_cs%0d", tag, i),    8'(idecs[i]), 8'h3);
            chk($sformatf("%s_dsack%0d", tag, i), 8'(dsack[i]), 8'h3);
            chk($sformatf("%s_tmo%0d", tag, i),   8'(tmo[i]),   8'h0);
        end
    endtask

    // One CPU cycle. AS20/IDE_SEL low on edges [t0, r); DS20 low on [t0+d, r);
    // IORDY low on [t0, e_r) where e_r is wait0 edges past instance 0's minimum ACK edge.
    // rmode>0 forces AS20 to rise at t0+rmode (possible abort).
    task automatic run_txn(input bit rw, input bit a12, input int d, input int wait0,
                           input int rmode, input int gap);
        int t0, req, r, e_r, c0, w;
        int n [2];
        int a [2];
        bit to [2];
        bit ab [2];
        bit act [2];
        logic       e_ior, e_iow, e_tmo;
        logic [1:0] e_cs, e_ds;
        bit in_cyc;

        t0  = cyc + 1 + gap;
        req = rw ? t0 : t0 + d;
        for (int i = 0; i < 2; i++)
            n[i] = (req > idle_from[i]) ? req : idle_from[i] + 1;
        e_r = n[0] + ts[0] + ta[0] + wait0;
        for (int i = 0; i < 2; i++) begin
            c0    = n[i] + ts[i] + ta[i];
            w     = (e_r > c0) ? e_r - c0 : 0;
            to[i] = (w > tt[i]);
            a[i]  = c0 + (to[i] ? tt[i] : w);
        end
        if (rmode > 0) r = t0 + rmode;
        else r = ((a[0] > a[1]) ? a[0] : a[1]) + 1 + int'($urandom_range(0, 3));
        for (int i = 0; i < 2; i++) begin
            act[i] = (r > n[i]);
            ab[i]  = act[i] && (r <= a[i]);
        end

        for (int k = cyc + 1; k <= r; k++) begin
            AS20    = !(k >= t0 && k < r);
            IDE_SEL = AS20;
            DS20    = !(k >= t0 + d && k < r);
            RW20    = rw;
            A12     = a12;
            IORDY   = !(k >= t0 && k < e_r);
            step();
            for (int i = 0; i < 2; i++) begin
                in_cyc = act[i] && (k >= n[i]) && (k < r);
                e_cs   = in_cyc ? (a12 ? 2'b01 : 2'b10) : 2'b11;
                e_ior  = !(in_cyc && rw  && k >= n[i] + ts[i]);
                e_iow  = !(in_cyc && !rw && k >= n[i] + ts[i]);
                e_ds   = (in_cyc && !ab[i] && k >= a[i]) ? 2'b01 : 2'b11;
                e_tmo  = act[i] && !ab[i] && to[i] && (k == a[i]);
                chk($sformatf("ior%0d", i),   8'(ior[i]),   8'(e_ior));
                chk($sformatf("iow%0d", i),   8'(iow[i]),   8'(e_iow));
                chk($sformatf("cs%0d", i),    8'(idecs[i]), 8'(e_cs));
                chk($sformatf("dsack%0d", i), 8'(dsack[i]), 8'(e_ds));
                chk($sformatf("tmo%0d", i),   8'(tmo[i]),   8'(e_tmo));
            end
        end
        for (int i = 0; i < 2; i++)
            if (act[i]) idle_from[i] = r + tr[i];
    endtask

    initial begin
        #2 RESET = 1'b0;
        step();
        step();
        chk_idle("reset");
        RESET = 1'b1;
        idle_from[0] = cyc;
        idle_from[1] = cyc;

        run_txn(1'b1, 1'b0, 0, 0,   0, 3);   // basic read
        run_txn(1'b0, 1'b1, 2, 0,   0, 5);   // write, DS20 two edges late
        run_txn(1'b1, 1'b1, 0, 10,  0, 5);   // 10 IORDY wait cycles
        run_txn(1'b0, 1'b0, 0, 300, 0, 5);   // IORDY stuck: both time out
        run_txn(1'b1, 1'b0, 0, 0,   3, 5);   // AS20 negated mid-cycle
        run_txn(1'b1, 1'b0, 0, 0,   0, 0);   // request pending during recovery

        for (int t = 0; t < 40; t++) begin
            int wsel, wv, rm;
            wsel = int'($urandom_range(0, 3));
            wv   = (wsel == 0) ? int'($urandom_range(1, 20)) : 0;
            rm   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0;
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), wv, rm, int'($urandom_range(0, 4)));
        end

        // reset while instance 0 is in its strobe phase
        AS20 = 1'b1; IDE_SEL = 1'b1; IORDY = 1'b1;
        for (int j = 0; j < 6; j++) step();
        AS20 = 1'b0; IDE_SEL = 1'b0; RW20 = 1'b1; A12 = 1'b0; IORDY = 1'b0;
        step();
        step();
        step();
        chk("pre_rst_ior0", 8'(ior[0]), 8'h0);
        chk("pre_rst_cs0",  8'(idecs[0]), 8'h2);
        #2 RESET = 1'b0;
        #1;
        chk_idle("async_rst");
        AS20 = 1'b1; IDE_SEL = 1'b1; IORDY = 1'b1;
        step();
        RESET = 1'b1;
        idle_from[0] = cyc;
        idle_from[1] = cyc;
        run_txn(1'b1, 1'b0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
